fpga_link_tx: RTL
=================

// Module: fpga_link_tx
// PURPOSE
//  Wire-level transmitter of the FPGA-to-FPGA link. Takes a DATA_WIDTH word from local
//  logic on a start pulse and serialises it onto tx_line as start/data/[parity]/stop.
//  It then holds busy until the remote receiver completes a four-phase ack.
//  The remote end asserts ack once its host has pulsed 'processed'.
// PARAMETERS
//  DATA_WIDTH    8     payload bits per frame
//  CLKS_PER_BIT  16    clock cycles each line bit is held (>=2)
//  ACK_TIMEOUT   4096  max cycles in each ack wait state before error (>=1)
// PORTS
//  clock     in   1           system clock, rising edge
//  reset_n   in   1           asynchronous, active-low reset
//  data_in   in   DATA_WIDTH  word to send; sampled only when a start is accepted
//  start     in   1           request; accepted only in IDLE
//  ack_in    in   1           ack from the remote FPGA (asynchronous, 2-flop synchronised)
//  tx_line   out  1           serial line, idle high
//  busy      out  1           high from the cycle after start is accepted until back in IDLE
//  done      out  1           1-cycle pulse when ack completes (ack_in fell)
//  error     out  1           1-cycle pulse on ack timeout
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tx_line=1, busy=0, done=0, error=0.
//  Reset also clears the counters, the shift register and the ack synchronisers.
//  Reset mid-frame aborts immediately; tx_line returns high and no done/error is issued.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> WAIT_ACK_HI -> WAIT_ACK_LO -> IDLE.
//  IDLE: when start=1, latch data_in into the shift register and go to START; busy=1 next cycle.
//   A start while not in IDLE is ignored, with no queueing.
//  START: tx_line=0 for CLKS_PER_BIT cycles.
//  DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
//   A bit counter wraps 0..DATA_WIDTH-1.
//  STOP: tx_line=1 for CLKS_PER_BIT cycles.
//  The frame occupies (DATA_WIDTH+2[+1])*CLKS_PER_BIT cycles of tx_line.
//  WAIT_ACK_HI: tx_line=1; wait for the synchronised ack=1, then go to WAIT_ACK_LO.
//  WAIT_ACK_LO: wait for the synchronised ack=0; then pulse done and go to IDLE (busy=0 the same cycle).
//  Timeout: the timeout counter is reset on entry to each wait state.
//   Reaching ACK_TIMEOUT cycles pulses error for 1 cycle and returns to IDLE; done is not pulsed.
//  ack_in already high on entry to WAIT_ACK_HI is accepted as a valid ack.
//  done and error are mutually exclusive and are never asserted outside their exit cycle.
//  A start in the same cycle as done/error is ignored, because state is not yet IDLE.
//  The ack synchroniser adds 2 cycles of latency to every ack edge.
// CONFIGURATION
//  FPGA_LINK_PARITY_EN defined: a PARITY state follows DATA.
//   It sends the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles.
//  FPGA_LINK_PARITY_EN undefined: there is no PARITY state; DATA goes directly to STOP.
// TESTING  (DATA_WIDTH=8, CLKS_PER_BIT=4, ACK_TIMEOUT=64)
//  1. Reset pulse low mid-idle -> tx_line=1, busy=0, done=0, error=0 immediately.
//  2. Send 0x2D (45), no parity -> tx_line per 4 cycles: 0,1,0,1,1,0,1,0,0,1.
//     busy=1 from the cycle after start.
//     Remote ack high then low -> done pulse 2 cycles after the ack fall; busy=0.
//  3. FPGA_LINK_PARITY_EN, send 0x2D -> parity bit 0 inserted before stop.
//     Send 0x01 -> parity bit 1.
//  4. start pulsed again during the DATA state of 0x2D -> ignored; the frame is unchanged.
//     Only one done is issued.
//  5. No ack after the frame -> error pulse exactly 64 cycles after WAIT_ACK_HI entry.
//     busy=0 the same cycle; done never asserted.
//  6. reset_n low during DATA of 0xA5 -> tx_line=1, busy=0 asynchronously.
//     After release, send 0x3C -> a clean full frame and done.

Source files
------------

// File: rtl/fpga_link_tx_if.sv
// Local-side handshake of the FPGA link transmitter: word/start in, busy/done/error back.
interface fpga_link_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output data_in,
    output start,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  data_in,
    input  start,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/fpga_link_tx.sv
// FPGA-to-FPGA link transmitter: start/data/[parity]/stop serialiser followed by a four-phase ack wait.
// Define FPGA_LINK_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fpga_link_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT  = 4096
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ack_in,
  output logic          tx_line,
  fpga_link_tx_if.slave link
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_ACK_HI,
    S_WAIT_ACK_LO
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_clk_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [TW-1:0]         r_to_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_ack_meta;
  logic                  r_ack_sync;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_serial;
  logic                  w_waiting;
  logic                  w_timeout;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_error;
`ifdef FPGA_LINK_PARITY_EN
  logic                  r_parity;
`endif

  assign w_bit_end  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_cnt == BW'(DATA_WIDTH - 1));
  assign w_serial   = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_waiting  = (r_state == S_WAIT_ACK_HI) || (r_state == S_WAIT_ACK_LO);
  assign w_timeout  = (r_to_cnt == TW'(ACK_TIMEOUT));
  assign w_accept   = (r_state == S_IDLE) && link.start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:        if (link.start) w_next_state = S_START;
      S_START:       if (w_bit_end) w_next_state = S_DATA;
      S_DATA: begin
        if (w_bit_end && w_last_bit) begin
`ifdef FPGA_LINK_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
      end
`ifdef FPGA_LINK_PARITY_EN
      S_PARITY:      if (w_bit_end) w_next_state = S_STOP;
`endif
      S_STOP:        if (w_bit_end) w_next_state = S_WAIT_ACK_HI;
      S_WAIT_ACK_HI: begin
        if (r_ack_sync)     w_next_state = S_WAIT_ACK_LO;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_WAIT_ACK_LO: begin
        if (!r_ack_sync || w_timeout) w_next_state = S_IDLE;
      end
      default:       w_next_state = S_IDLE;
    endcase
  end

  // done/error are decoded from the exit cycle itself, so busy drops with them
  // while the state register still holds the wait state and a start is ignored.
  always_comb begin
    tx_line = 1'b1;
    w_done  = 1'b0;
    w_error = 1'b0;
    case (r_state)
      S_START:       tx_line = 1'b0;
      S_DATA:        tx_line = r_shift[0];
`ifdef FPGA_LINK_PARITY_EN
      S_PARITY:      tx_line = r_parity;
`endif
      S_WAIT_ACK_HI: w_error = !r_ack_sync && w_timeout;
      S_WAIT_ACK_LO: begin
        w_done  = !r_ack_sync;
        w_error = r_ack_sync && w_timeout;
      end
      default:       tx_line = 1'b1;
    endcase
    link.done  = w_done;
    link.error = w_error;
    link.busy  = (r_state != S_IDLE) && !w_done && !w_error;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_sync <= 1'b0;
    end else begin
      r_ack_meta <= ack_in;
      r_ack_sync <= r_ack_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_shift   <= '0;
    end else begin
      if (!w_serial || w_bit_end) r_clk_cnt <= '0;
      else                        r_clk_cnt <= r_clk_cnt + 1'b1;

      if (r_state == S_DATA && w_bit_end) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        r_shift   <= r_shift >> 1;
      end else if (w_accept) begin
        r_bit_cnt <= '0;
        r_shift   <= link.data_in;
      end

      // Restarting on any state change gives each wait state its own full budget.
      if (!w_waiting || (w_next_state != r_state)) r_to_cnt <= '0;
      else                                         r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

`ifdef FPGA_LINK_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_parity <= 1'b0;
    else if (w_accept) r_parity <= ^link.data_in;
  end
`endif

endmodule
